// File: rtl/cla_operand_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : cla_operand_issue_if
// Description : Operand-source and result-sink handshake bundle for the
//               CLA operand issue block.
// Revision    : 1.0 - initial release
// ============================================================================
interface cla_operand_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, res_ready,
        input  in_ready, res_valid, res_sum, res_cout, res_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, res_ready,
        output in_ready, res_valid, res_sum, res_cout, res_ovf
    );
endinterface
`default_nettype wire

// File: rtl/cla_operand_issue.sv
`default_nettype none
// ============================================================================
// Module      : cla_operand_issue
// Description : Operand FIFO, registered adder drive and result register
//               around a combinational CLA. Optional macro CLA_ISSUE_SAT_EN
//               saturates the captured sum on signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_operand_issue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire                     clk,
    input  wire                     rst_n,
    cla_operand_issue_if.slave      bus,
    output logic [WIDTH-1:0]        adder_a,
    output logic [WIDTH-1:0]        adder_b,
    output logic                    adder_cin,
    input  wire  [WIDTH-1:0]        adder_sum,
    input  wire                     adder_cout,
    input  wire                     adder_ovf,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_EW = 2 * WIDTH + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [c_EW-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_adder_a;
    logic [WIDTH-1:0] r_adder_b;
    logic             r_adder_cin;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_sum;
    logic             r_res_cout;
    logic             r_res_ovf;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [c_EW-1:0]  w_entry;
    logic [c_EW-1:0]  w_head;
    logic [c_LW-1:0]  w_level_nxt;
    logic [WIDTH-1:0] w_res_sum;

    // Subtraction is folded into the stored entry so the adder only ever adds.
    assign w_entry = {bus.in_a, (bus.in_sub ? ~bus.in_b : bus.in_b), (bus.in_sub | bus.in_cin)};
    assign w_head  = r_mem[r_rd_ptr];
    assign w_empty = (r_level == '0);
    assign w_push  = bus.in_valid & r_in_ready;
    assign w_pop   = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_HOLD) & bus.res_ready));

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + {{c_AW{1'b0}}, 1'b1};
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - {{c_AW{1'b0}}, 1'b1};
        end
    end

`ifdef CLA_ISSUE_SAT_EN
    assign w_res_sum = adder_ovf ? (r_adder_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                       : {1'b0, {(WIDTH-1){1'b1}}})
                                 : adder_sum;
`else
    assign w_res_sum = adder_sum;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // in_ready is registered from the next occupancy so res_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level    <= w_level_nxt;
            r_in_ready <= (w_level_nxt != c_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_adder_a   <= '0;
            r_adder_b   <= '0;
            r_adder_cin <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {r_adder_a, r_adder_b, r_adder_cin} <= w_head;
                        r_state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_res_sum   <= w_res_sum;
                    r_res_cout  <= adder_cout;
                    r_res_ovf   <= adder_ovf;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            {r_adder_a, r_adder_b, r_adder_cin} <= w_head;
                            r_state <= S_DRIVE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_sum   = r_res_sum;
    assign bus.res_cout  = r_res_cout;
    assign bus.res_ovf   = r_res_ovf;
    assign adder_a       = r_adder_a;
    assign adder_b       = r_adder_b;
    assign adder_cin     = r_adder_cin;
    assign fifo_level    = r_level;
endmodule
`default_nettype wire
